// File: rtl/coin_credit.sv
// coin_credit: coin acceptance, spend absorption and fewest-coin change return.
// Define COIN_CREDIT_SYNC_EN to synchronise and edge-detect the Coin/Refund inputs.
module coin_credit #(
   parameter int unsigned MAX_CREDIT = 100,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [2:0] Coin,
   input  logic       Refund,
   input  logic [6:0] C,
   output logic [6:0] Money,
   output logic       CoinReject,
   output logic       Busy,
   output logic       RetQ,
   output logic       RetD,
   output logic       RetN
);
   localparam int unsigned CW = 7;
   localparam int unsigned SW = CW + 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHANGE,
      S_PULSE,
      S_GAP,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [CW-1:0] credit_q, cprev_q, remain_q, money_q;
   logic [GW-1:0] gap_q;
   logic          rej_q, busy_q, retq_q, retd_q, retn_q;

   logic [2:0]    coin_ev;
   logic          refund_ev;
   logic [CW-1:0] delta_c, base_c, coin_val_c;
   logic [SW-1:0] sum_c;
   logic          coin_ok_c;

`ifdef COIN_CREDIT_SYNC_EN
   logic [3:0] sync1_q, sync2_q, prev_q;

   // Two-flop synchroniser plus rising-edge detect: one event per press.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= {Refund, Coin};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign {refund_ev, coin_ev} = sync2_q & ~prev_q;
`else
   assign coin_ev   = Coin;
   assign refund_ev = Refund;
`endif

   // Credit after absorbing this cycle's spend, and the candidate coin insert.
   always_comb begin
      delta_c    = C - cprev_q;
      base_c     = credit_q + delta_c;
      coin_val_c = '0;
      case (coin_ev)
         3'b001:  coin_val_c = CW'(5);
         3'b010:  coin_val_c = CW'(10);
         3'b100:  coin_val_c = CW'(25);
         default: coin_val_c = '0;
      endcase
      sum_c     = {1'b0, base_c} + {1'b0, coin_val_c};
      coin_ok_c = (coin_val_c != '0) && (sum_c <= SW'(MAX_CREDIT));
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         credit_q <= '0;
         cprev_q  <= '0;
         remain_q <= '0;
         money_q  <= '0;
         gap_q    <= '0;
         rej_q    <= 1'b0;
         busy_q   <= 1'b0;
         retq_q   <= 1'b0;
         retd_q   <= 1'b0;
         retn_q   <= 1'b0;
      end else begin
         cprev_q <= C;
         rej_q   <= |coin_ev;
         retq_q  <= 1'b0;
         retd_q  <= 1'b0;
         retn_q  <= 1'b0;
         money_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (refund_ev) begin
                  remain_q <= base_c;
                  credit_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_CHANGE;
               end else begin
                  money_q  <= credit_q;
                  credit_q <= coin_ok_c ? sum_c[CW-1:0] : base_c;
                  rej_q    <= (|coin_ev) && !coin_ok_c;
               end
            end
            // Greedy pick; a remainder below a nickel is dropped.
            S_CHANGE: begin
               if (remain_q >= CW'(25)) begin
                  retq_q   <= 1'b1;
                  remain_q <= remain_q - CW'(25);
                  state_q  <= S_PULSE;
               end else if (remain_q >= CW'(10)) begin
                  retd_q   <= 1'b1;
                  remain_q <= remain_q - CW'(10);
                  state_q  <= S_PULSE;
               end else if (remain_q >= CW'(5)) begin
                  retn_q   <= 1'b1;
                  remain_q <= remain_q - CW'(5);
                  state_q  <= S_PULSE;
               end else begin
                  state_q  <= S_DONE;
               end
            end
            S_PULSE: begin
               gap_q   <= GW'(GAP_CYCLES - 1);
               state_q <= S_GAP;
            end
            S_GAP: begin
               if (gap_q == '0) begin
                  state_q <= S_CHANGE;
               end else begin
                  gap_q <= gap_q - GW'(1);
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign Money      = money_q;
   assign CoinReject = rej_q;
   assign Busy       = busy_q;
   assign RetQ       = retq_q;
   assign RetD       = retd_q;
   assign RetN       = retn_q;

endmodule

// File: tb/tb_coin_credit.sv
// tb_coin_credit: directed and randomized checks of coin_credit against an
// arithmetic credit model and a greedy change-making reference.
module tb_coin_credit;
   localparam int MAXC = 100;
   localparam int GAP  = 1;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic [2:0] Coin = 3'b000;
   logic       Refund = 1'b0;
   logic [6:0] C = 7'd0;
   logic [6:0] Money;
   logic       CoinReject, Busy, RetQ, RetD, RetN;

   int ntests = 0;
   int nfail  = 0;
   int mcred  = 0;
   int cnow   = 0;

   coin_credit #(.MAX_CREDIT(MAXC), .GAP_CYCLES(GAP)) dut (
      .Clk(Clk), .Reset(Reset), .Coin(Coin), .Refund(Refund), .C(C),
      .Money(Money), .CoinReject(CoinReject), .Busy(Busy),
      .RetQ(RetQ), .RetD(RetD), .RetN(RetN)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      ntests++;
      assert (obs === exp_v) else begin
         nfail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic int coin_value(input logic [2:0] c);
      if ($countones(c) != 1) return 0;
      if (c[0]) return 5;
      if (c[1]) return 10;
      return 25;
   endfunction

   // One IDLE cycle: spend `spend` from the credit and offer `coin`.
   task automatic step(input logic [2:0] coin, input int spend);
      int   old, base, v;
      logic exp_rej;
      old  = mcred;
      cnow = cnow - spend;
      C    = 7'(cnow);
      base = mcred - spend;
      v    = coin_value(coin);
      if (v != 0 && base + v <= MAXC) begin
         mcred   = base + v;
         exp_rej = 1'b0;
      end else begin
         mcred   = base;
         exp_rej = (coin != 3'b000);
      end
      Coin = coin;
      @(posedge Clk); #1;
      Coin = 3'b000;
      chk("reject", {7'd0, CoinReject}, {7'd0, exp_rej});
      chk("money", {1'b0, Money}, 8'(old));
      chk("busy_idle", {7'd0, Busy}, 8'd0);
   endtask

   task automatic do_reset();
      Reset = 1'b1; Coin = 3'b000; Refund = 1'b0; C = 7'd0;
      cnow = 0; mcred = 0;
      #1;
      chk("rst_money", {1'b0, Money}, 8'd0);
      chk("rst_busy", {7'd0, Busy}, 8'd0);
      chk("rst_reject", {7'd0, CoinReject}, 8'd0);
      chk("rst_ret", {5'd0, RetQ, RetD, RetN}, 8'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
   endtask

   // Refund the model credit and compare the pulse train with greedy change.
   task automatic do_refund(input logic [2:0] coin, input logic stress);
      int         remain, n, idx, busy_cnt;
      int         exp_kind[$];
      int         kind[$];
      int         pos[$];
      logic [2:0] pc;
      remain = mcred;
      repeat (remain / 25) exp_kind.push_back(0);
      repeat ((remain % 25) / 10) exp_kind.push_back(1);
      repeat ((remain % 25 % 10) / 5) exp_kind.push_back(2);
      n = exp_kind.size();
      Refund = 1'b1; Coin = coin;
      @(posedge Clk); #1;
      Refund = 1'b0; Coin = 3'b000;
      mcred = 0;
      chk("refund_reject", {7'd0, CoinReject}, {7'd0, coin != 3'b000});
      chk("refund_busy", {7'd0, Busy}, 8'd1);
      chk("refund_money", {1'b0, Money}, 8'd0);
      idx = 0;
      busy_cnt = 1;
      while (Busy === 1'b1 && idx < 200) begin
         pc = (stress && $urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         Coin = pc;
         Refund = stress ? ($urandom_range(0, 3) == 0) : 1'b0;
         @(posedge Clk); #1;
         idx++;
         Coin = 3'b000; Refund = 1'b0;
         chk("busy_reject", {7'd0, CoinReject}, {7'd0, pc != 3'b000});
         chk("busy_money", {1'b0, Money}, 8'd0);
         if (Busy === 1'b1) busy_cnt++;
         if (RetQ === 1'b1 || RetD === 1'b1 || RetN === 1'b1) begin
            chk("ret_onehot", 8'($countones({RetQ, RetD, RetN})), 8'd1);
            pos.push_back(idx);
            kind.push_back(RetQ ? 0 : (RetD ? 1 : 2));
         end
      end
      chk("refund_end", {7'd0, Busy}, 8'd0);
      chk("busy_len", 8'(busy_cnt), 8'((GAP + 2) * n + 2));
      chk("pulse_count", 8'(kind.size()), 8'(n));
      for (int i = 0; i < kind.size() && i < n; i++) begin
         chk("pulse_kind", 8'(kind[i]), 8'(exp_kind[i]));
         chk("pulse_pos", 8'(pos[i]), 8'(1 + (GAP + 2) * i));
      end
   endtask

   initial begin
      int       r, sp, room, qcnt;
      logic [2:0] cn;

      // Two quarters.
      do_reset();
      step(3'b100, 0);
      step(3'b100, 0);
      step(3'b000, 0);
      chk("dir_money50", {1'b0, Money}, 8'd50);

      // Spend absorption from the cumulative C bus.
      step(3'b000, 15);
      step(3'b000, 0);
      chk("dir_money35", {1'b0, Money}, 8'd35);
      step(3'b000, 30);
      step(3'b000, 0);
      chk("dir_money5", {1'b0, Money}, 8'd5);

      // Refund of 65 gives Q Q D N.
      do_reset();
      step(3'b100, 0); step(3'b100, 0); step(3'b010, 0); step(3'b001, 0);
      do_refund(3'b000, 1'b0);
      step(3'b000, 0);
      step(3'b000, 0);
      chk("dir_after_refund", {1'b0, Money}, 8'd0);

      // MAX_CREDIT boundary.
      do_reset();
      step(3'b100, 0); step(3'b100, 0); step(3'b100, 0); step(3'b010, 0); step(3'b001, 0);
      step(3'b100, 0);
      chk("dir_q_reject", {7'd0, CoinReject}, 8'd1);
      step(3'b000, 0);
      chk("dir_money90", {1'b0, Money}, 8'd90);
      step(3'b010, 0);
      step(3'b001, 0);
      chk("dir_n_reject", {7'd0, CoinReject}, 8'd1);
      step(3'b000, 0);
      chk("dir_money100", {1'b0, Money}, 8'd100);

      // Multi-coin strobe, then coin together with refund.
      step(3'b011, 0);
      step(3'b000, 0);
      chk("dir_multi_money", {1'b0, Money}, 8'd100);
      do_refund(3'b100, 1'b0);

      // Reset during the second quarter pulse of a 65 refund.
      do_reset();
      step(3'b100, 0); step(3'b100, 0); step(3'b010, 0); step(3'b001, 0);
      Refund = 1'b1;
      @(posedge Clk); #1;
      Refund = 1'b0;
      qcnt = 0;
      for (int i = 0; i < 30 && qcnt < 2; i++) begin
         @(posedge Clk); #1;
         if (RetQ === 1'b1) qcnt++;
      end
      chk("second_q_seen", 8'(qcnt), 8'd2);
      do_reset();
      step(3'b010, 0);
      step(3'b000, 0);
      chk("dir_after_reset10", {1'b0, Money}, 8'd10);

      // Randomized traffic against the model.
      for (int it = 0; it < 200; it++) begin
         r = $urandom_range(0, 99);
         if (r < 50) begin
            step(3'(1 << $urandom_range(0, 2)), 0);
         end else if (r < 58) begin
            case ($urandom_range(0, 3))
               0:       cn = 3'b011;
               1:       cn = 3'b101;
               2:       cn = 3'b110;
               default: cn = 3'b111;
            endcase
            step(cn, 0);
         end else if (r < 82) begin
            room = (mcred < 64 + cnow) ? mcred : 64 + cnow;
            sp = (room > 0) ? $urandom_range(0, room) : 0;
            cn = ($urandom_range(0, 1) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            step(cn, sp);
         end else if (r < 94) begin
            cn = ($urandom_range(0, 2) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            do_refund(cn, 1'b1);
         end else begin
            do_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/coin_credit.md
Name: coin_credit

Overview:
- Upstream stage of the vending purchase block.
- Accepts nickel/dime/quarter inserts and keeps a running credit. The purchase block reads this credit as its Money input.
- Each cycle, absorbs that block's cumulative spend bus C into the credit.
- On Refund, pays back the remaining credit as a timed sequence of coin-return pulses using the fewest coins.

Parameters:
- MAX_CREDIT, 100, highest credit allowed after a coin insert (must be ≤ 127).
- GAP_CYCLES, 1, low cycles inserted after each change pulse (≥ 1).

Ports:
- Clk  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Coin  input  3  insert strobes: [0] nickel (5), [1] dime (10), [2] quarter (25).
- Refund  input  1  request return of all credit.
- C  input  7  cumulative spend from the purchase block; two's complement, ≤ 0, 0 after Reset.
- Money  output  7  registered credit presented to the purchase block.
- CoinReject  output  1  one-cycle pulse when an insert is refused.
- Busy  output  1  high while change is being paid.
- RetQ  output  1  one-cycle quarter-return pulse.
- RetD  output  1  one-cycle dime-return pulse.
- RetN  output  1  one-cycle nickel-return pulse.

Behaviour:
- Reset (async): Credit=0, CPrev=0, Money=0, state IDLE; all pulses, CoinReject and Busy low.
- Spend absorption, every cycle in IDLE:
  - Delta = C − CPrev (7-bit wrap).
  - CPrev <= C.
  - Base = Credit + Delta. The purchase block never drives this negative.
- Coin decode, IDLE only:
  - Exactly one Coin bit set: value V. If Base+V ≤ MAX_CREDIT then Credit <= Base+V; else Credit <= Base and CoinReject pulses.
  - More than one Coin bit set: Credit <= Base, CoinReject pulses.
  - No Coin bits set: Credit <= Base.
- Money mirrors Credit with one cycle of latency: an insert sampled at edge k is visible after edge k+1.
- Refund in IDLE:
  - Takes priority over a same-cycle Coin. That coin is rejected with a CoinReject pulse.
  - Remain <= Base, Credit <= 0, state CHANGE, Busy=1 from the next cycle.
- States:
  - IDLE: normal operation.
  - CHANGE: pick a coin. Remain ≥ 25 → RetQ, Remain −= 25; else ≥ 10 → RetD, −= 10; else ≥ 5 → RetN, −= 5; else → DONE. Any remainder below 5 is discarded.
  - PULSE: the chosen Ret* is high for exactly this one cycle, then go to GAP.
  - GAP: GAP_CYCLES low cycles, then back to CHANGE.
  - DONE: one cycle with Busy=1, then IDLE with Busy=0.
- During CHANGE, PULSE, GAP and DONE:
  - Money is held at 0, so the purchase block cannot vend.
  - Coin inserts are refused: each sampled insert pulses CoinReject.
  - Refund is ignored.
  - CPrev keeps tracking C; Delta is discarded.
- Refund with Credit 0: go to CHANGE → DONE → IDLE with no Ret* pulse. Busy is high for 2 cycles.
- Reset mid-refund: pulses stop immediately and outputs return to reset values.
- Ret* pulses are mutually exclusive and never adjacent (at least GAP_CYCLES apart).

Optional Feature:
- Macro COIN_CREDIT_SYNC_EN.
- Defined:
  - Coin and Refund each pass through a 2-flop synchronizer followed by rising-edge detection.
  - Each press acts once regardless of how long it is held.
  - Adds 2 cycles of input latency; everything downstream is unchanged.
- Undefined: Coin and Refund are treated as synchronous single-cycle strobes, sampled directly.

Test Plan (macro undefined, defaults):
- Reset, then quarter strobe, then quarter strobe → Money=50 one cycle after the second strobe; CoinReject never pulses.
- Credit 50; C steps 0 → 7'b1110001 (−15) → Money=35 next cycle. Then C → 7'b1010011 (−45) → Money=5.
- Credit 65; Refund → Busy rises; pulses RetQ, RetQ, RetD, RetN, each 1 cycle and 2 cycles apart; then Busy falls and Money stays 0.
- Credit 90: quarter → CoinReject pulse, Money stays 90; then dime → Money=100; then nickel → rejected, Money stays 100.
- Coin=3'b011 in one cycle → CoinReject, Money unchanged. Coin and Refund in the same cycle → CoinReject, and the refund proceeds.
- Reset asserted during the second RetQ of a 65 refund → all outputs 0 immediately; after release a dime gives Money=10.
